// File: rtl/cfg_write_ctrl.sv
// Configuration write controller: collects NUM_REGS payload bytes plus an XOR
// checksum byte from a byte stream and commits them to the config registers.
module cfg_write_ctrl #(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned NUM_REGS = 11,
  parameter  int unsigned TIMEOUT  = 50000,
  localparam int unsigned CNT_W    = $clog2(NUM_REGS + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_wr,
  input  logic              rxrdy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              abort,
  output logic              shift_rxregs,
  output logic              load_confregs,
  output logic              done_wr,
  output logic              err_wr,
  output logic              busy,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic [2:0]        wr_leds
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  // State encoding doubles as the LED code.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RECV = 3'd1,
    S_LOAD = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd7
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [DATA_W-1:0]   acc, acc_d;
  logic [IDLE_W-1:0]   idle_cnt, idle_d;
  logic                shift_d;

  // Next-state, counters and checksum accumulator.
  always_comb begin
    state_d = state;
    cnt_d   = byte_cnt;
    acc_d   = acc;
    idle_d  = idle_cnt;
    shift_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (rxrdy && start_wr && !abort) begin
          state_d = S_RECV;
          cnt_d   = CNT_W'(1);
          acc_d   = rx_data;
          idle_d  = '0;
          shift_d = 1'b1;
        end
      end
      S_RECV: begin
        if (abort || !start_wr) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (rxrdy) begin
          idle_d = '0;
          if (byte_cnt == CNT_W'(NUM_REGS)) begin
            cnt_d   = CNT_W'(NUM_REGS + 1);
            state_d = (rx_data == acc) ? S_LOAD : S_ERR;
          end else begin
            cnt_d   = byte_cnt + CNT_W'(1);
            acc_d   = acc ^ rx_data;
            shift_d = 1'b1;
          end
        end else begin
          idle_d = idle_cnt + IDLE_W'(1);
          if (idle_d == IDLE_W'(TIMEOUT)) state_d = S_ERR;
        end
      end
      S_LOAD: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      S_ERR: begin
        if (!start_wr) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      byte_cnt      <= '0;
      acc           <= '0;
      idle_cnt      <= '0;
      shift_rxregs  <= 1'b0;
      load_confregs <= 1'b0;
      done_wr       <= 1'b0;
      err_wr        <= 1'b0;
      busy          <= 1'b0;
      wr_leds       <= 3'd0;
    end else begin
      state         <= state_d;
      byte_cnt      <= cnt_d;
      acc           <= acc_d;
      idle_cnt      <= idle_d;
      shift_rxregs  <= shift_d;
      load_confregs <= (state_d == S_LOAD);
      done_wr       <= (state_d == S_DONE);
      err_wr        <= (state_d == S_ERR);
      busy          <= (state_d == S_RECV) || (state_d == S_LOAD) || (state_d == S_DONE);
      wr_leds       <= 3'(state_d);
    end
  end

endmodule

// File: tb/tb_cfg_write_ctrl.sv
// Bench for cfg_write_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a frame-level reference model.
module tb_cfg_write_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 3;
  localparam int unsigned TO = 20;
  localparam int unsigned CW = $clog2(NR + 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_wr, rxrdy, abort;
  logic [DW-1:0] rx_data;
  logic          shift_rxregs, load_confregs, done_wr, err_wr, busy;
  logic [CW-1:0] byte_cnt;
  logic [2:0]    wr_leds;

  cfg_write_ctrl #(.DATA_W(DW), .NUM_REGS(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_wr(start_wr), .rxrdy(rxrdy),
    .rx_data(rx_data), .abort(abort), .shift_rxregs(shift_rxregs),
    .load_confregs(load_confregs), .done_wr(done_wr), .err_wr(err_wr),
    .busy(busy), .byte_cnt(byte_cnt), .wr_leds(wr_leds)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic          st, rx, ab;
    logic [DW-1:0] d;
    logic [10:0]   exp;
  } vec_t;

  vec_t vq[$];

  // Output bundle: {shift, load, done, err, busy, byte_cnt[2:0], leds[2:0]}
  function automatic logic [10:0] mk(input logic sh, ld, dn, er, bs, input int cnt, input int leds);
    return {sh, ld, dn, er, bs, 3'(cnt), 3'(leds)};
  endfunction

  function automatic logic [10:0] outs();
    return {shift_rxregs, load_confregs, done_wr, err_wr, busy, 3'(byte_cnt), wr_leds};
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got sh/ld/dn/er/bs/cnt/led=%b required %b", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, rx, input logic [7:0] d, input logic ab,
                     input logic sh, ld, dn, er, bs, input int cnt, input int leds);
    vec_t v;
    v.st = st; v.rx = rx; v.d = d; v.ab = ab;
    v.exp = mk(sh, ld, dn, er, bs, cnt, leds);
    vq.push_back(v);
  endtask

  // One clock: drive inputs, take the edge, sample 1ns later.
  task automatic cyc(input string nm, input logic st, rx, input logic [7:0] d, input logic ab,
                     input logic [10:0] exp);
    start_wr = st; rxrdy = rx; rx_data = d; abort = ab;
    @(posedge clk);
    #1;
    check(nm, outs(), exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start_wr = 1'b0; rxrdy = 1'b0; abort = 1'b0; rx_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Frame-level reference model
  bit          m_frame, m_err;
  int          m_commit, m_gap, m_cnt;
  logic [7:0]  m_q[$];
  logic        m_sh;

  function automatic logic [7:0] xor_q();
    logic [7:0] r = '0;
    foreach (m_q[k]) r ^= m_q[k];
    return r;
  endfunction

  task automatic model_clear();
    m_frame = 0; m_err = 0; m_commit = 0; m_gap = 0; m_cnt = 0; m_sh = 0;
    m_q.delete();
  endtask

  task automatic model_step(input logic st, rx, input logic [7:0] d, input logic ab);
    m_sh = 0;
    if (m_err) begin
      if (!st) begin m_err = 0; m_cnt = 0; end
    end else if (m_commit > 0) begin
      m_commit--;
      if (m_commit == 0) m_cnt = 0;
    end else if (m_frame) begin
      if (ab || !st) begin
        m_frame = 0; m_cnt = 0;
      end else if (rx) begin
        m_gap = 0;
        if (m_q.size() == NR) begin
          m_frame = 0;
          m_cnt   = NR + 1;
          if (d == xor_q()) m_commit = 2;
          else              m_err = 1;
        end else begin
          m_q.push_back(d);
          m_cnt = m_q.size();
          m_sh  = 1;
        end
      end else begin
        m_gap++;
        if (m_gap == TO) begin m_frame = 0; m_err = 1; end
      end
    end else if (rx && st && !ab) begin
      m_q.delete();
      m_q.push_back(d);
      m_frame = 1; m_cnt = 1; m_sh = 1; m_gap = 0;
    end
  endtask

  function automatic logic [10:0] model_exp();
    int leds;
    leds = m_err ? 7 : (m_commit == 2) ? 2 : (m_commit == 1) ? 3 : m_frame ? 1 : 0;
    return mk(m_sh, m_commit == 2, m_commit == 1, m_err, m_frame || (m_commit > 0), m_cnt, leds);
  endfunction

  initial begin
    rst_n = 1'b0; start_wr = 1'b0; rxrdy = 1'b0; abort = 1'b0; rx_data = '0;
    #2;
    check("reset_state", outs(), 11'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Good frame, with rxrdy ignored during LOAD and DONE
    add(1,1,8'h12,0, 1,0,0,0,1, 1,1);
    add(1,1,8'h34,0, 1,0,0,0,1, 2,1);
    add(1,1,8'h56,0, 1,0,0,0,1, 3,1);
    add(1,1,8'h70,0, 0,1,0,0,1, 4,2);
    add(1,1,8'h99,0, 0,0,1,0,1, 4,3);
    add(1,1,8'h99,0, 0,0,0,0,0, 0,0);
    add(1,0,8'h00,0, 0,0,0,0,0, 0,0);
    // Bad checksum: ERR holds until start_wr drops, rxrdy ignored
    add(1,1,8'h12,0, 1,0,0,0,1, 1,1);
    add(1,1,8'h34,0, 1,0,0,0,1, 2,1);
    add(1,1,8'h56,0, 1,0,0,0,1, 3,1);
    add(1,1,8'h71,0, 0,0,0,1,0, 4,7);
    add(1,1,8'h12,0, 0,0,0,1,0, 4,7);
    add(1,0,8'h00,0, 0,0,0,1,0, 4,7);
    add(0,0,8'h00,0, 0,0,0,0,0, 0,0);
    // Abort beats a simultaneous rxrdy
    add(1,1,8'h12,0, 1,0,0,0,1, 1,1);
    add(1,1,8'h34,1, 0,0,0,0,0, 0,0);
    add(1,0,8'h00,0, 0,0,0,0,0, 0,0);
    // start_wr dropping mid-frame returns to IDLE quietly
    add(1,1,8'h05,0, 1,0,0,0,1, 1,1);
    add(0,1,8'h06,0, 0,0,0,0,0, 0,0);
    // Back-to-back frame, checksum 0x01^0x02^0x03 = 0x00
    add(1,1,8'h01,0, 1,0,0,0,1, 1,1);
    add(1,1,8'h02,0, 1,0,0,0,1, 2,1);
    add(1,1,8'h03,0, 1,0,0,0,1, 3,1);
    add(1,1,8'h00,0, 0,1,0,0,1, 4,2);
    add(1,0,8'h00,0, 0,0,1,0,1, 4,3);
    add(1,0,8'h00,0, 0,0,0,0,0, 0,0);

    foreach (vq[i]) cyc($sformatf("vec%0d", i), vq[i].st, vq[i].rx, vq[i].d, vq[i].ab, vq[i].exp);

    // Timeout: 19 idle cycles stay in RECV, the 20th enters ERR
    cyc("to_b1", 1,1,8'h12,0, mk(1,0,0,0,1, 1,1));
    cyc("to_b2", 1,1,8'h34,0, mk(1,0,0,0,1, 2,1));
    for (int k = 1; k < int'(TO); k++)
      cyc($sformatf("to_wait%0d", k), 1,0,8'h00,0, mk(0,0,0,0,1, 2,1));
    cyc("to_expire", 1,0,8'h00,0, mk(0,0,0,1,0, 2,7));
    cyc("to_hold",   1,1,8'h56,0, mk(0,0,0,1,0, 2,7));
    cyc("to_exit",   0,0,8'h00,0, mk(0,0,0,0,0, 0,0));

    // Asynchronous reset mid-frame, then a clean frame
    cyc("rs_b1", 1,1,8'h12,0, mk(1,0,0,0,1, 1,1));
    cyc("rs_b2", 1,1,8'h34,0, mk(1,0,0,0,1, 2,1));
    rxrdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rs_async", outs(), 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rs_f1", 1,1,8'hAA,0, mk(1,0,0,0,1, 1,1));
    cyc("rs_f2", 1,1,8'hBB,0, mk(1,0,0,0,1, 2,1));
    cyc("rs_f3", 1,1,8'hCC,0, mk(1,0,0,0,1, 3,1));
    cyc("rs_f4", 1,1,8'hDD,0, mk(0,1,0,0,1, 4,2));
    cyc("rs_f5", 1,0,8'h00,0, mk(0,0,1,0,1, 4,3));
    cyc("rs_f6", 1,0,8'h00,0, mk(0,0,0,0,0, 0,0));

    // Randomized run against the reference model
    do_reset();
    model_clear();
    for (int i = 0; i < 4000; i++) begin
      logic st, rx, ab;
      logic [7:0] d;
      st = ($urandom_range(0, 99) < 94);
      ab = ($urandom_range(0, 99) < 2);
      rx = ((i % 300) < 260) ? ($urandom_range(0, 99) < 45) : 1'b0;
      d  = 8'($urandom);
      if (m_frame && m_q.size() == NR && $urandom_range(0, 1) == 1) d = xor_q();
      start_wr = st; rxrdy = rx; rx_data = d; abort = ab;
      @(posedge clk);
      model_step(st, rx, d, ab);
      #1;
      check($sformatf("rand%0d", i), outs(), model_exp());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfg_write_ctrl.md
CFG_WRITE_CTRL -- requirements
Module: cfg_write_ctrl

Interface
REQ-001 Parameter DATA_W, 8, width of one received byte.
REQ-002 Parameter NUM_REGS, 11, payload bytes per frame (>=1); one checksum byte follows the payload.
REQ-003 Parameter TIMEOUT, 50000, maximum clk cycles allowed between consecutive accepted bytes inside a frame (>=2).
REQ-004 Local parameter CNT_W SHALL be the minimum width holding NUM_REGS+1.
REQ-005 clk  input  1  single system clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start_wr  input  1  write mode enable, level.
REQ-008 rxrdy  input  1  one-cycle strobe: rx_data valid.
REQ-009 rx_data  input  DATA_W  received byte.
REQ-010 abort  input  1  cancel the current frame, level.
REQ-011 shift_rxregs  output  1  one-cycle pulse: shift one payload byte into the receive registers.
REQ-012 load_confregs  output  1  one-cycle pulse: copy the receive registers into the config registers.
REQ-013 done_wr  output  1  one-cycle pulse: frame committed.
REQ-014 err_wr  output  1  frame failed (checksum or timeout), level.
REQ-015 busy  output  1  frame in progress.
REQ-016 byte_cnt  output  CNT_W  bytes accepted in the current frame.
REQ-017 wr_leds  output  3  state code for the board LEDs.

Function
REQ-018 The FSM SHALL have states IDLE, RECV, LOAD, DONE and ERR; all outputs SHALL be registered.
REQ-019 In IDLE, rxrdy=1 with start_wr=1 and abort=0 at edge N SHALL accept the first payload byte and enter RECV at edge N.
REQ-020 Each accepted payload byte SHALL pulse shift_rxregs high for exactly the cycle following its sampling edge, increment byte_cnt, and XOR rx_data into a DATA_W checksum accumulator cleared on entry to RECV.
REQ-021 In RECV, the byte accepted when byte_cnt==NUM_REGS SHALL be the checksum byte; it SHALL NOT pulse shift_rxregs.
REQ-022 A checksum byte equal to the accumulator SHALL enter LOAD; a mismatch SHALL enter ERR.
REQ-023 LOAD SHALL last one cycle with load_confregs=1, then DONE SHALL last one cycle with done_wr=1, then the FSM SHALL return to IDLE.
REQ-024 In RECV, an idle counter SHALL clear on every accepted byte and SHALL enter ERR when it reaches TIMEOUT.
REQ-025 In RECV, abort=1 or start_wr=0 SHALL return to IDLE on the next edge with no load, no done_wr and no err_wr; abort SHALL take priority over a simultaneous rxrdy.
REQ-026 ERR SHALL hold err_wr=1 until start_wr=0, then return to IDLE; rxrdy in ERR SHALL be ignored.
REQ-027 rxrdy in LOAD or DONE SHALL be ignored, with no byte accepted and byte_cnt unchanged.
REQ-028 byte_cnt SHALL clear on every entry to IDLE and SHALL never exceed NUM_REGS+1.
REQ-029 busy SHALL be 1 in RECV, LOAD and DONE, and 0 otherwise.
REQ-030 wr_leds SHALL be IDLE=0, RECV=1, LOAD=2, DONE=3 and ERR=7.
REQ-031 Back-to-back rxrdy strobes (every cycle) SHALL each be accepted in RECV.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, clear byte_cnt, the accumulator and the idle counter, drive every output to 0, and abort any frame in progress without a load.
REQ-033 After rst_n rises, the first accepted byte SHALL be treated as payload byte 1.

Verification (NUM_REGS=3, DATA_W=8, TIMEOUT=20)
REQ-034 Good frame: start_wr=1, bytes 0x12, 0x34, 0x56, 0x70 -> three shift_rxregs pulses, load_confregs for 1 cycle, done_wr on the next cycle, byte_cnt reaches 4, then IDLE with wr_leds=0.
REQ-035 Bad checksum: bytes 0x12, 0x34, 0x56, 0x71 -> no load_confregs, err_wr=1 and wr_leds=7 until start_wr=0, then IDLE.
REQ-036 Timeout: bytes 0x12, 0x34, then 20 idle cycles -> ERR, err_wr=1, no load.
REQ-037 Abort: abort=1 asserted together with the second byte -> IDLE, byte_cnt=0, only one shift_rxregs pulse, no err_wr.
REQ-038 Reset mid-frame: rst_n=0 after 2 bytes -> all outputs 0 immediately; next frame 0xAA, 0xBB, 0xCC, 0xDD commits.
REQ-039 Back-to-back: four rxrdy strobes on consecutive cycles with a correct checksum -> three consecutive shift_rxregs pulses and a commit.
